// File: rtl/mux_n_reg_pkg.sv
// Shared pipeline helpers: select-width derivation for N-way selectors.
package mux_n_reg_pkg;

    // Select width for an n-way selector; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way word selector; out-of-range selects yield zero.
module mux_n_sel
    import mux_n_reg_pkg::*;
#(
    parameter int unsigned   LENGTH = 32,
    parameter int unsigned   INPUTS = 4,
    localparam int unsigned  SEL_W  = sel_width(INPUTS)
) (
    input  logic [INPUTS*LENGTH-1:0] in_data,
    input  logic [SEL_W-1:0]         select,
    output logic [LENGTH-1:0]        word_c,
    output logic                     out_of_range_c
);

    // Decode select and route the chosen word, zero when no word matches
    always_comb begin
        word_c         = '0;
        out_of_range_c = (32'(select) >= INPUTS);
        for (int unsigned k = 0; k < INPUTS; k++) begin
            if (32'(select) == k) begin
                word_c = in_data[k*LENGTH +: LENGTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way selector stage with valid/ready handshake, flush and
// a flagged zero result for out-of-range selects.
module mux_n_reg
    import mux_n_reg_pkg::*;
#(
    parameter int unsigned   LENGTH = 32,
    parameter int unsigned   INPUTS = 4,
    localparam int unsigned  SEL_W  = sel_width(INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INPUTS*LENGTH-1:0] in_data,
    input  logic [SEL_W-1:0]         select,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [LENGTH-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LENGTH-1:0]   data_q;
    logic [LENGTH-1:0]   data_d;
    logic                err_q;
    logic                err_d;
    logic [LENGTH-1:0]   word_c;
    logic                oor_c;
    logic                accept_c;

    mux_n_sel #(
        .LENGTH (LENGTH),
        .INPUTS (INPUTS)
    ) u_sel (
        .in_data        (in_data),
        .select         (select),
        .word_c         (word_c),
        .out_of_range_c (oor_c)
    );

    // Ready whenever the slot is free or is being emptied this cycle
    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign sel_err   = err_q;

    // State and payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next state: flush beats accept, accept beats drain, otherwise hold
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        err_d    = err_q;
        accept_c = in_valid && in_ready && !flush;

        if (flush) begin
            state_d = ST_EMPTY;
            err_d   = 1'b0;
        end else if (accept_c) begin
            state_d = ST_FULL;
            data_d  = word_c;
            err_d   = oor_c;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: driver predicts captured entries, the
// monitor checks handshake state every cycle and each transfer in order.
module tb_mux_n_reg;

    localparam int unsigned LENGTH = 32;
    localparam int unsigned INPUTS = 5;
    localparam int unsigned SEL_W  = 3;

    typedef struct packed {
        logic [LENGTH-1:0] data;
        logic              err;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [INPUTS*LENGTH-1:0] in_data = '0;
    logic [SEL_W-1:0]         select = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     flush = 1'b0;
    logic [LENGTH-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic                     sel_err;

    mux_n_reg #(
        .LENGTH (LENGTH),
        .INPUTS (INPUTS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .select    (select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    // Reference state: queue of held entries plus what the output shows
    exp_t              q[$];
    logic [LENGTH-1:0] words [INPUTS];
    logic [LENGTH-1:0] shown_data = '0;
    logic              shown_err  = 1'b0;
    bit                armed      = 1'b0;
    bit                pend_rst   = 1'b1;
    bit                pend_flush = 1'b0;
    bit                pend_acc   = 1'b0;
    exp_t              pend_e;
    int                n_cmp      = 0;
    int                n_bad      = 0;
    int                n_xfer     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply what the previous cycle's inputs do at this edge
    task automatic commit();
        if (pend_rst) begin
            q.delete();
            shown_data = '0;
            shown_err  = 1'b0;
        end else if (pend_flush) begin
            q.delete();
            shown_err = 1'b0;
        end else if (pend_acc) begin
            q.push_back(pend_e);
            shown_data = pend_e.data;
            shown_err  = pend_e.err;
        end
    endtask

    // One cycle of stimulus; expectation recorded for the coming edge
    task automatic step(input bit r, input bit v, input int s, input bit f, input bit o);
        @(posedge clk);
        commit();
        armed = 1'b1;
        #1;
        rst       = r;
        in_valid  = v;
        select    = SEL_W'(s);
        flush     = f;
        out_ready = o;
        for (int k = 0; k < int'(INPUTS); k++) in_data[k*LENGTH +: LENGTH] = words[k];
        pend_rst    = r;
        pend_flush  = f;
        pend_acc    = v && !r && !f && ((q.size() == 0) || o);
        pend_e.data = (s < int'(INPUTS)) ? words[s] : '0;
        pend_e.err  = (s >= int'(INPUTS));
    endtask

    task automatic rand_words();
        for (int k = 0; k < int'(INPUTS); k++) words[k] = $urandom;
    endtask

    // Monitor: per-cycle handshake/hold checks and in-order transfer checks
    always @(negedge clk) begin
        if (armed) begin
            check("in_ready",  32'(in_ready),  32'((q.size() == 0) || out_ready));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("out_data",  out_data,       shown_data);
            check("sel_err",   32'(sel_err),   32'(shown_err));
            if (out_valid && out_ready && !rst && !flush && (q.size() != 0)) begin
                exp_t e;
                e = q.pop_front();
                n_xfer++;
                check("xfer_data", out_data,     e.data);
                check("xfer_err",  32'(sel_err), 32'(e.err));
            end
        end
    end

    initial begin
        for (int k = 0; k < int'(INPUTS); k++) words[k] = 32'(k + 1) * 32'h1111_1111;

        // Reset held with in_valid high
        step(1, 1, 2, 0, 1);
        step(1, 1, 2, 0, 1);

        // Basic select then back-to-back sweep
        step(0, 1, 2, 0, 1);
        for (int s = 0; s < int'(INPUTS); s++) step(0, 1, s, 0, 1);
        step(0, 0, 0, 0, 1);

        // Stall with changing inputs, then same-edge replace
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            rand_words();
            step(0, 1, i + 2, 0, 0);
        end
        for (int k = 0; k < int'(INPUTS); k++) words[k] = 32'(k + 1) * 32'h1111_1111;
        step(0, 1, 3, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Out-of-range selects, then in-range clears the flag
        step(0, 1, 6, 0, 1);
        step(0, 1, 5, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Flush while full and stalled, in_valid dropped
        step(0, 1, 7, 0, 0);
        step(0, 1, 3, 0, 0);
        step(0, 1, 4, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Reset during a stall
        step(0, 1, 1, 0, 0);
        step(0, 1, 2, 0, 0);
        step(1, 1, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_words();
            step(($urandom_range(63) == 0), ($urandom_range(9) < 7),
                 int'($urandom_range(7)), ($urandom_range(15) == 0),
                 ($urandom_range(9) < 6));
        end

        // Drain and confirm nothing is left outstanding
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        @(posedge clk);
        commit();
        #1;
        check("queue_empty", 32'(q.size()), 32'd0);
        check("some_xfers",  32'(n_xfer > 100), 32'd1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Runaway guard
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
